// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the CPU (C) and GPU (G) ports.
// One access in flight at a time; read data is routed back to the port that issued it.
module data_mem_arbiter #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 16,
  parameter int MEM_LATENCY = 2
) (
  input  logic                  I_CLOCK,
  input  logic                  I_LOCK,
  input  logic                  I_C_Req,
  input  logic                  I_C_We,
  input  logic [15:0]           I_C_Addr,
  input  logic [DATA_WIDTH-1:0] I_C_WData,
  output logic                  O_C_Gnt,
  output logic                  O_C_RValid,
  output logic [DATA_WIDTH-1:0] O_C_RData,
  input  logic                  I_G_Req,
  input  logic                  I_G_We,
  input  logic [15:0]           I_G_Addr,
  input  logic [DATA_WIDTH-1:0] I_G_WData,
  output logic                  O_G_Gnt,
  output logic                  O_G_RValid,
  output logic [DATA_WIDTH-1:0] O_G_RData,
  output logic                  O_MemEn,
  output logic                  O_MemWe,
  output logic [ADDR_WIDTH-1:0] O_MemAddr,
  output logic [DATA_WIDTH-1:0] O_MemWData,
  input  logic [DATA_WIDTH-1:0] I_MemRData,
  output logic                  O_Busy
);

  typedef enum logic {IDLE, RD_WAIT} state_t;

  localparam int CNT_W = 3;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  lastG_q, lastG_d;
  logic                  ownerG_q, ownerG_d;
  logic                  cGnt_q, cGnt_d, gGnt_q, gGnt_d;
  logic                  memEn_q, memEn_d, memWe_q, memWe_d;
  logic [ADDR_WIDTH-1:0] memAddr_q, memAddr_d;
  logic [DATA_WIDTH-1:0] memWData_q, memWData_d;
  logic                  cRValid_q, cRValid_d, gRValid_q, gRValid_d;
  logic [DATA_WIDTH-1:0] cRData_q, cRData_d, gRData_q, gRData_d;
  logic                  busy_q, busy_d;

  logic                  cElig, gElig, pickG, selWe;
  logic [15:0]           selAddr;
  logic [DATA_WIDTH-1:0] selWData;

  // Bit 0 (word alignment) and bits above the line address are dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{I_C_Addr[0], I_G_Addr[0],
                              I_C_Addr[15:ADDR_WIDTH+1], I_G_Addr[15:ADDR_WIDTH+1]};

  // A port granted last cycle is masked so it cannot win again while dropping Req.
  assign cElig    = I_C_Req && !cGnt_q;
  assign gElig    = I_G_Req && !gGnt_q;
  assign pickG    = gElig && (!cElig || !lastG_q);
  assign selWe    = pickG ? I_G_We    : I_C_We;
  assign selAddr  = pickG ? I_G_Addr  : I_C_Addr;
  assign selWData = pickG ? I_G_WData : I_C_WData;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lastG_d    = lastG_q;
    ownerG_d   = ownerG_q;
    cGnt_d     = 1'b0;
    gGnt_d     = 1'b0;
    memEn_d    = 1'b0;
    memWe_d    = 1'b0;
    memAddr_d  = memAddr_q;
    memWData_d = memWData_q;
    cRValid_d  = 1'b0;
    gRValid_d  = 1'b0;
    cRData_d   = cRData_q;
    gRData_d   = gRData_q;
    busy_d     = busy_q;

    case (state_q)
      IDLE: begin
        if (cElig || gElig) begin
          cGnt_d     = !pickG;
          gGnt_d     = pickG;
          memEn_d    = 1'b1;
          memWe_d    = selWe;
          memAddr_d  = selAddr[ADDR_WIDTH:1];
          memWData_d = selWData;
          lastG_d    = pickG;
          if (!selWe) begin
            state_d  = RD_WAIT;
            cnt_d    = CNT_W'(MEM_LATENCY - 1);
            ownerG_d = pickG;
            busy_d   = 1'b1;
          end
        end
      end
      RD_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          if (ownerG_q) begin
            gRData_d  = I_MemRData;
            gRValid_d = 1'b1;
          end else begin
            cRData_d  = I_MemRData;
            cRValid_d = 1'b1;
          end
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // lastG resets to 1 so the CPU wins the first tie.
  always_ff @(negedge I_CLOCK or negedge I_LOCK) begin
    if (!I_LOCK) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      lastG_q    <= 1'b1;
      ownerG_q   <= 1'b0;
      cGnt_q     <= 1'b0;
      gGnt_q     <= 1'b0;
      memEn_q    <= 1'b0;
      memWe_q    <= 1'b0;
      memAddr_q  <= '0;
      memWData_q <= '0;
      cRValid_q  <= 1'b0;
      gRValid_q  <= 1'b0;
      cRData_q   <= '0;
      gRData_q   <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lastG_q    <= lastG_d;
      ownerG_q   <= ownerG_d;
      cGnt_q     <= cGnt_d;
      gGnt_q     <= gGnt_d;
      memEn_q    <= memEn_d;
      memWe_q    <= memWe_d;
      memAddr_q  <= memAddr_d;
      memWData_q <= memWData_d;
      cRValid_q  <= cRValid_d;
      gRValid_q  <= gRValid_d;
      cRData_q   <= cRData_d;
      gRData_q   <= gRData_d;
      busy_q     <= busy_d;
    end
  end

  assign O_C_Gnt    = cGnt_q;
  assign O_G_Gnt    = gGnt_q;
  assign O_C_RValid = cRValid_q;
  assign O_G_RValid = gRValid_q;
  assign O_C_RData  = cRData_q;
  assign O_G_RData  = gRData_q;
  assign O_MemEn    = memEn_q;
  assign O_MemWe    = memWe_q;
  assign O_MemAddr  = memAddr_q;
  assign O_MemWData = memWData_q;
  assign O_Busy     = busy_q;

endmodule
